pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Decides each cycle whether PC and IF/ID hold (if_stall), whether IF/ID is flushed (taken branch/jump), and whether ID/EX receives a bubble.
- Also sequences the multi-cycle mult/div unit with a busy counter, stalling the front end while a HI/LO-dependent instruction waits.
- State updates on posedge clk. Outputs are combinational from state and inputs, settled before the pipeline registers sample on negedge clk.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/hazard_match.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared types and constants for the pipeline hazard logic
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         MD_CYCLES_DEF = 32;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// ============================================================================
// hazard_match : does the ID instruction read register reg_i (never $zero)
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_match
  import pipe_pkg::*;
(
  input  logic [4:0] reg_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       uses_rs_i,
  input  logic       uses_rt_i,
  output logic       hit_o
);

  assign hit_o = (reg_i != REG_ZERO) &&
                 ((uses_rs_i && (rs_i == reg_i)) || (uses_rt_i && (rt_i == reg_i)));

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush sequencer and mult/div busy tracker
// Optional perf counters under HAZ_PERF_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       id_branch_taken,
  input  logic       id_md_start,
  input  logic       id_reads_hilo,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_wr_reg,
  input  logic       ex_reg_write,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_wr_reg,
  output logic       if_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       md_go,
  output logic       md_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] md_stall_cycles
`endif
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic hit_ex_ld, hit_ex_alu, hit_mem_ld;
  logic lu_ex, br_ex, br_mem;
  logic data_stall, md_stall, stall;
  logic go_raw;

  hazard_match u_match_ex_ld (
    .reg_i     (ex_wr_reg),
    .rs_i      (id_rs),
    .rt_i      (id_rt),
    .uses_rs_i (id_uses_rs),
    .uses_rt_i (id_uses_rt),
    .hit_o     (hit_ex_ld)
  );

  hazard_match u_match_ex_alu (
    .reg_i     (ex_wr_reg),
    .rs_i      (id_rs),
    .rt_i      (id_rt),
    .uses_rs_i (id_uses_rs),
    .uses_rt_i (id_uses_rt),
    .hit_o     (hit_ex_alu)
  );

  hazard_match u_match_mem_ld (
    .reg_i     (mem_wr_reg),
    .rs_i      (id_rs),
    .rt_i      (id_rt),
    .uses_rs_i (id_uses_rs),
    .uses_rt_i (id_uses_rt),
    .hit_o     (hit_mem_ld)
  );

  // Branches compare in ID, so an ALU result still in EX cannot be forwarded in time.
  assign lu_ex      = ex_mem_read && hit_ex_ld;
  assign br_ex      = id_is_branch && ex_reg_write && !ex_mem_read && hit_ex_alu;
  assign br_mem     = id_is_branch && mem_mem_read && hit_mem_ld;
  assign data_stall = lu_ex | br_ex | br_mem;
  assign md_stall   = (state_q == MD_WAIT) && (id_reads_hilo || id_md_start);
  assign stall      = data_stall | md_stall;
  assign go_raw     = id_md_start && !stall && (state_q == RUN);

  // Everything is gated by rst so outputs drop the instant reset asserts.
  assign if_stall    = rst && stall;
  assign id_ex_flush = rst && stall;
  assign if_id_flush = rst && id_branch_taken && !stall;
  assign md_go       = rst && go_raw;
  assign md_busy     = rst && (state_q == MD_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (go_raw) begin
            state_q <= MD_WAIT;
            cnt_q   <= CNT_W'(MD_CYCLES - 1);
          end
        end
        MD_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles    <= '0;
      flush_count     <= '0;
      md_stall_cycles <= '0;
    end else begin
      stall_cycles    <= sat_inc(stall_cycles, stall);
      flush_count     <= sat_inc(flush_count, if_id_flush);
      md_stall_cycles <= sat_inc(md_stall_cycles, md_stall);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : directed self-checking bench for pipe_hazard_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_wr_reg, mem_wr_reg;
  logic       id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken;
  logic       id_md_start, id_reads_hilo, ex_mem_read, ex_reg_write, mem_mem_read;
  logic       if_stall, if_id_flush, id_ex_flush, md_go, md_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, md_stall_cycles;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_is_branch    (id_is_branch),
    .id_branch_taken (id_branch_taken),
    .id_md_start     (id_md_start),
    .id_reads_hilo   (id_reads_hilo),
    .ex_mem_read     (ex_mem_read),
    .ex_wr_reg       (ex_wr_reg),
    .ex_reg_write    (ex_reg_write),
    .mem_mem_read    (mem_mem_read),
    .mem_wr_reg      (mem_wr_reg),
    .if_stall        (if_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .md_go           (md_go),
    .md_busy         (md_busy)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
    .md_stall_cycles (md_stall_cycles)
`endif
  );

  // Expected vector order: {if_stall, if_id_flush, id_ex_flush, md_go, md_busy}
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {if_stall, if_id_flush, id_ex_flush, md_go, md_busy};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [4:0] exp);
    @(negedge clk);
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; ex_wr_reg = 5'd0; mem_wr_reg = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_branch = 1'b0; id_branch_taken = 1'b0;
    id_md_start = 1'b0; id_reads_hilo = 1'b0; ex_mem_read = 1'b0;
    ex_reg_write = 1'b0; mem_mem_read = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    id_md_start = 1'b1;
    #3 chk("reset_outputs_low", 5'b00000);
    @(posedge clk); #1;
    rst = 1'b1;
    clr();
    cyc("idle", 5'b00000);

    // load-use
    ex_mem_read = 1'b1; ex_wr_reg = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8;
    cyc("load_use_rs", 5'b10100);
    ex_mem_read = 1'b0; mem_mem_read = 1'b1; mem_wr_reg = 5'd8;
    cyc("load_use_released", 5'b00000);
    clr();
    ex_mem_read = 1'b1; ex_wr_reg = 5'd0; id_uses_rs = 1'b1; id_rs = 5'd0;
    cyc("load_use_reg_zero", 5'b00000);
    ex_wr_reg = 5'd9; id_rs = 5'd8;
    cyc("load_use_no_match", 5'b00000);
    id_uses_rs = 1'b0; id_uses_rt = 1'b1; id_rt = 5'd9;
    cyc("load_use_rt", 5'b10100);
    id_uses_rt = 1'b0;
    cyc("load_use_rt_unused", 5'b00000);
    clr();

    // load then branch: lu_ex stall, br_mem stall, then flush
    ex_mem_read = 1'b1; ex_wr_reg = 5'd9; id_is_branch = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd9;
    cyc("ld_br_lu_ex", 5'b10100);
    ex_mem_read = 1'b0; ex_wr_reg = 5'd0; mem_mem_read = 1'b1; mem_wr_reg = 5'd9;
    cyc("ld_br_br_mem", 5'b10100);
    mem_mem_read = 1'b0; id_branch_taken = 1'b1;
    cyc("ld_br_flush", 5'b01000);
    clr();
    cyc("ld_br_after", 5'b00000);

    // stall over flush via br_ex
    id_is_branch = 1'b1; ex_reg_write = 1'b1; ex_wr_reg = 5'd5; id_uses_rs = 1'b1; id_rs = 5'd5;
    id_branch_taken = 1'b1;
    cyc("br_ex_stall_over_flush", 5'b10100);
    ex_reg_write = 1'b0;
    cyc("br_ex_then_flush", 5'b01000);
    id_branch_taken = 1'b0; ex_reg_write = 1'b1; id_is_branch = 1'b0;
    cyc("alu_dep_non_branch", 5'b00000);
    clr();

    // mult/div with MD_CYCLES=4
    id_md_start = 1'b1;
    cyc("md_go", 5'b00010);
    id_md_start = 1'b0; id_reads_hilo = 1'b1;
    cyc("mflo_wait_1", 5'b10101);
    cyc("mflo_wait_2", 5'b10101);
    cyc("mflo_wait_3", 5'b10101);
    cyc("mflo_proceed", 5'b00000);
    clr();
    id_md_start = 1'b1;
    cyc("md_go_2", 5'b00010);
    id_md_start = 1'b0; id_uses_rs = 1'b1; id_rs = 5'd3;
    cyc("indep_add_in_busy", 5'b00001);
    clr();
    id_md_start = 1'b1;
    cyc("md_start_in_busy_1", 5'b10101);
    cyc("md_start_in_busy_2", 5'b10101);
    cyc("md_start_issues", 5'b00010);
    clr();
    cyc("busy_cnt3", 5'b00001);

    // reset while MD_WAIT with cnt=2
    id_md_start = 1'b1;
    #1 chk("pre_reset_stall", 5'b10101);
    rst = 1'b0;
    #1 chk("async_reset", 5'b00000);
    @(posedge clk); #1;
    rst = 1'b1;
    clr();
    cyc("post_reset_run", 5'b00000);
    id_md_start = 1'b1;
    cyc("post_reset_go", 5'b00010);
    clr();

`ifdef HAZ_PERF_CNT_EN
    rst = 1'b0;
    #1 chk32("perf_reset_stall", stall_cycles, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ex_mem_read = 1'b1; ex_wr_reg = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8;
      cyc("perf_load_use", 5'b10100);
      clr();
      cyc("perf_gap", 5'b00000);
    end
    id_branch_taken = 1'b1;
    cyc("perf_branch", 5'b01000);
    clr();
    chk32("perf_stall_cycles", stall_cycles, 32'd2);
    chk32("perf_flush_count", flush_count, 32'd1);
    chk32("perf_md_stall_cycles", md_stall_cycles, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
